// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling, LSB-first word out.
// Latency: rx_valid rises 3 + CLKS_PER_BIT/2 + (DATA_WIDTH+1+PARITY_EN)*CLKS_PER_BIT edges after rx is first sampled low.
// Backpressure: none; rx_valid is a one-cycle strobe and an unconsumed word is overwritten by the next frame.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [1:0]            sync_q, sync_d;
    logic [1:0]            prime_q, prime_d;
    logic                  hist_q, hist_d;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  perr_q, perr_d;
    logic                  stop_q, stop_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;

    logic rx_s;
    logic start_cond;

    assign rx_s       = sync_q[1];
    assign start_cond = hist_q & ~rx_s;

    // Next-state logic: synchroniser, edge history and the frame FSM.
    always_comb begin
        sync_d       = {sync_q[0], rx};
        // The synchroniser holds reset values for two edges after reset; the
        // history flop only learns from real line samples, so a line held low
        // through reset must be seen high before a falling edge counts.
        prime_d      = {prime_q[0], 1'b1};
        hist_d       = prime_q[1] ? rx_s : 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sh_d         = sh_q;
        perr_d       = perr_q;
        stop_d       = stop_q;
        done_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_cond) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    // Line back high at mid-start is a glitch: drop it silently.
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                // Counting from mid-start, each full bit period lands on mid-bit.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[DATA_WIDTH-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = rx_s ^ (^sh_q) ^ ODD_BIT;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (done_q) begin
                    // Publish one edge after the stop sample and rearm at once,
                    // leaving half a bit to catch a back-to-back start edge.
                    state_d      = IDLE;
                    rx_data_d    = sh_q;
                    rx_valid_d   = 1'b1;
                    parity_err_d = perr_q;
                    frame_err_d  = ~stop_q;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    stop_d = rx_s;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 2'b11;
            prime_q      <= 2'b00;
            hist_q       <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_q         <= '0;
            perr_q       <= 1'b0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prime_q      <= prime_d;
            hist_q       <= hist_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            perr_q       <= perr_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance without parity, one with even parity.
// Latency: strobe times checked against the frame start edge.
// Backpressure: none; every strobe is matched against the expectation queue.
module tb_uart_rx;

    localparam int C    = 16;
    localparam int LAT0 = 2 + C / 2 + 9 * C + 1;
    localparam int LAT1 = LAT0 + C;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] rx_data0, rx_data1;
    logic       v0, v1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt0 = 0;
    int   snap = 0;
    logic done = 1'b0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .rx(rx0), .rx_data(rx_data0), .rx_valid(v0),
        .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
    );

    uart_rx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(rx_data1), .rx_valid(v1),
        .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) rx0 = b;
        else rx1 = b;
    endtask

    task automatic hold_bit(input int sel, input logic b);
        set_line(sel, b);
        repeat (C) @(negedge clk);
    endtask

    // Called at a negedge; queues the expected strobe and drives a full frame.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                              input logic par_bit, input logic stop_bit, input logic expect_it);
        exp_t x;
        x.d  = d;
        x.fe = ~stop_bit;
        x.pe = use_par ? (par_bit != (^d)) : 1'b0;
        x.t  = cyc + 1 + (use_par ? LAT1 : LAT0);
        if (expect_it) begin
            if (sel == 0) sb0.push_back(x);
            else sb1.push_back(x);
        end
        hold_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
        if (use_par) hold_bit(sel, par_bit);
        hold_bit(sel, stop_bit);
    endtask

    initial begin
        fork
            begin : monitor
                while (!done) begin
                    @(negedge clk);
                    if (busy0) busy_cnt0 = busy_cnt0 + 1;
                    if (v0) begin
                        chk("strobe0_expected", 32'(sb0.size() != 0), 1);
                        if (sb0.size() != 0) begin
                            e = sb0.pop_front();
                            chk("data0", 32'(rx_data0), 32'(e.d));
                            chk("perr0", 32'(perr0), 32'(e.pe));
                            chk("ferr0", 32'(ferr0), 32'(e.fe));
                            chk("time0", 32'(cyc), 32'(e.t));
                        end
                    end else begin
                        chk("idle_flags0", 32'({perr0, ferr0}), 0);
                    end
                    if (v1) begin
                        chk("strobe1_expected", 32'(sb1.size() != 0), 1);
                        if (sb1.size() != 0) begin
                            e = sb1.pop_front();
                            chk("data1", 32'(rx_data1), 32'(e.d));
                            chk("perr1", 32'(perr1), 32'(e.pe));
                            chk("ferr1", 32'(ferr1), 32'(e.fe));
                            chk("time1", 32'(cyc), 32'(e.t));
                        end
                    end else begin
                        chk("idle_flags1", 32'({perr1, ferr1}), 0);
                    end
                end
            end
            begin : stimulus
                // Reset values.
                repeat (2) @(negedge clk);
                chk("rst_data", 32'(rx_data0), 0);
                chk("rst_valid", 32'(v0), 0);
                chk("rst_busy", 32'(busy0), 0);
                chk("rst_flags", 32'({perr0, ferr0}), 0);
                chk("rst_data_p", 32'(rx_data1), 0);
                rst = 1'b0;
                repeat (20) @(negedge clk);

                // Single frame, then busy must be low.
                send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
                repeat (8) @(negedge clk);
                chk("busy_after_a5", 32'(busy0), 0);

                // Back-to-back frames with no idle gap.
                send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
                send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
                repeat (8) @(negedge clk);

                // Framing error, then a clean frame.
                send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
                rx0 = 1'b1;
                repeat (2 * C) @(negedge clk);
                send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
                repeat (8) @(negedge clk);

                // Even parity: correct bit, then wrong bit.
                send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
                send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
                repeat (8) @(negedge clk);

                // Short glitch: busy pulses, no strobe, then a real frame.
                snap = busy_cnt0;
                rx0 = 1'b0;
                repeat (5) @(negedge clk);
                rx0 = 1'b1;
                repeat (30) @(negedge clk);
                chk("glitch_busy_pulse", 32'(busy_cnt0 > snap), 1);
                chk("glitch_back_idle", 32'(busy0), 0);
                send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
                repeat (8) @(negedge clk);

                // Reset during data bit 3 of 0x81: frame discarded.
                hold_bit(0, 1'b0);
                hold_bit(0, 1'b1);
                hold_bit(0, 1'b0);
                hold_bit(0, 1'b0);
                rx0 = 1'b0;
                repeat (C / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_data", 32'(rx_data0), 0);
                chk("midrst_valid", 32'(v0), 0);
                chk("midrst_busy", 32'(busy0), 0);
                chk("midrst_flags", 32'({perr0, ferr0}), 0);
                snap = busy_cnt0;
                repeat (C / 2) @(negedge clk);
                for (int i = 4; i < 8; i++) hold_bit(0, (i == 7));
                hold_bit(0, 1'b1);
                repeat (2 * C) @(negedge clk);
                chk("midrst_no_restart", 32'(busy_cnt0), 32'(snap));

                // Line held low through reset release: no start until it goes high.
                rx0 = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                snap = busy_cnt0;
                repeat (40) @(negedge clk);
                chk("held_low_no_start", 32'(busy_cnt0), 32'(snap));
                rx0 = 1'b1;
                repeat (2 * C) @(negedge clk);
                send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
                repeat (40) @(negedge clk);

                chk("all_strobes_seen0", 32'(sb0.size()), 0);
                chk("all_strobes_seen1", 32'(sb1.size()), 0);
                done = 1'b1;
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
